// File: rtl/unstripe_ctrl.sv
// Two-lane un-striping sequencer: pops lane 0 / lane 1 alternately, aligns skew, flushes on error.
// Optional feature: define UNSTRIPE_ERRCNT_EN to add the saturating err_count output.
module unstripe_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SKEW_MAX   = 4
) (
    input  logic                  clk_2f,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] lane_0,
    input  logic [DATA_WIDTH-1:0] lane_1,
    input  logic                  empty_0,
    input  logic                  empty_1,
    input  logic                  ready_out,
    output logic                  pop_0,
    output logic                  pop_1,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  active,
`ifdef UNSTRIPE_ERRCNT_EN
    output logic [7:0]            err_count,
`endif
    output logic                  skew_err
);

    localparam int unsigned CntW = $clog2(SKEW_MAX + 1);

    typedef enum logic [2:0] {
        StIdle,
        StAlign,
        StRun0,
        StRun1,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  skew_err_q, skew_err_d;
`ifdef UNSTRIPE_ERRCNT_EN
    logic [7:0]            err_count_q, err_count_d;
`endif

    // Saturating increment so the stall counter never wraps.
    assign cnt_inc = (cnt_q == CntW'(SKEW_MAX)) ? cnt_q : cnt_q + CntW'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        skew_err_d = skew_err_q;
        pop_0      = 1'b0;
        pop_1      = 1'b0;
`ifdef UNSTRIPE_ERRCNT_EN
        err_count_d = err_count_q;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!empty_0 && !empty_1) begin
                    state_d = StRun0;
                end else if (!empty_0 || !empty_1) begin
                    state_d = StAlign;
                end
            end
            StAlign: begin
                if (!empty_0 && !empty_1) begin
                    state_d = StRun0;
                    cnt_d   = '0;
                end else if (!empty_0 || !empty_1) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CntW'(SKEW_MAX)) state_d = StErr;
                end else begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StRun0: begin
                if (ready_out) begin
                    if (!empty_0) begin
                        pop_0   = 1'b1;
                        data_d  = lane_0;
                        valid_d = 1'b1;
                        state_d = StRun1;
                        cnt_d   = '0;
                    end else if (empty_1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(SKEW_MAX)) state_d = StErr;
                    end
                end
            end
            StRun1: begin
                if (ready_out) begin
                    if (!empty_1) begin
                        pop_1   = 1'b1;
                        data_d  = lane_1;
                        valid_d = 1'b1;
                        state_d = StRun0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CntW'(SKEW_MAX)) state_d = StErr;
                    end
                end
            end
            StErr: begin
                // Flush whatever is left in both lanes; the words are discarded.
                pop_0 = !empty_0;
                pop_1 = !empty_1;
                cnt_d = '0;
                if (empty_0 && empty_1) state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        if (state_d == StErr && state_q != StErr) begin
            skew_err_d = 1'b1;
`ifdef UNSTRIPE_ERRCNT_EN
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
`endif
        end

        if (reset) begin
            pop_0 = 1'b0;
            pop_1 = 1'b0;
        end
    end

    always_ff @(posedge clk_2f) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            skew_err_q <= 1'b0;
`ifdef UNSTRIPE_ERRCNT_EN
            err_count_q <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            skew_err_q <= skew_err_d;
`ifdef UNSTRIPE_ERRCNT_EN
            err_count_q <= err_count_d;
`endif
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign skew_err  = skew_err_q;
    assign active    = (state_q == StRun0) || (state_q == StRun1);
`ifdef UNSTRIPE_ERRCNT_EN
    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_unstripe_ctrl.sv
// Directed bench for unstripe_ctrl with behavioural lane FIFOs and hand-computed expectations.
module tb_unstripe_ctrl;

    logic        clk_2f = 1'b0;
    logic        reset;
    logic [31:0] lane_0, lane_1;
    logic        empty_0, empty_1;
    logic        ready_out;
    logic        pop_0, pop_1;
    logic [31:0] data_out;
    logic        valid_out;
    logic        active;
    logic        skew_err;
`ifdef UNSTRIPE_ERRCNT_EN
    logic [7:0]  err_count;
`endif

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int errors = 0;
    int checks = 0;

    always #5 clk_2f = ~clk_2f;

    unstripe_ctrl #(
        .DATA_WIDTH(32),
        .SKEW_MAX  (4)
    ) u_dut (
        .clk_2f   (clk_2f),
        .reset    (reset),
        .lane_0   (lane_0),
        .lane_1   (lane_1),
        .empty_0  (empty_0),
        .empty_1  (empty_1),
        .ready_out(ready_out),
        .pop_0    (pop_0),
        .pop_1    (pop_1),
        .data_out (data_out),
        .valid_out(valid_out),
        .active   (active),
`ifdef UNSTRIPE_ERRCNT_EN
        .err_count(err_count),
`endif
        .skew_err (skew_err)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic upd();
        empty_0 = (q0.size() == 0);
        empty_1 = (q1.size() == 0);
        lane_0  = empty_0 ? 32'h0 : q0[0];
        lane_1  = empty_1 ? 32'h0 : q1[0];
    endtask

    // One clock: sample pops before the edge, retire popped FIFO heads after it.
    task automatic tick();
        logic p0, p1;
        #1;
        p0 = pop_0;
        p1 = pop_1;
        if (p0 && empty_0) check("pop0_when_empty", {31'd0, p0}, 32'd0);
        if (p1 && empty_1) check("pop1_when_empty", {31'd0, p1}, 32'd0);
        @(posedge clk_2f);
        #1;
        if (p0 && q0.size() > 0) void'(q0.pop_front());
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        upd();
    endtask

    task automatic expect_word(input string tag, input logic [31:0] w);
        tick();
        check({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
        check({tag, "_data"}, data_out, w);
    endtask

    // Lane 1 never fills: 4 ALIGN stall cycles, then ERR flushes the 3 lane-0 words.
    task automatic run_align_err(input logic prev_err);
        q0 = {32'hC0, 32'hC1, 32'hC2};
        upd();
        repeat (4) tick();
        check("t5_pre_err", {31'd0, skew_err}, {31'd0, prev_err});
        tick();
        check("t5_err_set", {31'd0, skew_err}, 32'd1);
        check("t5_err_active", {31'd0, active}, 32'd0);
        #1;
        check("t5_flush_pop0", {31'd0, pop_0}, 32'd1);
        check("t5_flush_pop1", {31'd0, pop_1}, 32'd0);
        repeat (3) begin
            tick();
            check("t5_flush_valid", {31'd0, valid_out}, 32'd0);
        end
        check("t5_flushed", q0.size(), 32'd0);
        tick();
    endtask

    initial begin
        // 1: reset held with both lanes non-empty
        reset     = 1'b1;
        ready_out = 1'b1;
        q0 = {32'h11};
        q1 = {32'h22};
        upd();
        #2;
        check("t1_pop0", {31'd0, pop_0}, 32'd0);
        check("t1_pop1", {31'd0, pop_1}, 32'd0);
        tick();
        tick();
        check("t1_q0_kept", q0.size(), 32'd1);
        check("t1_valid", {31'd0, valid_out}, 32'd0);
        check("t1_data", data_out, 32'd0);
        check("t1_skew", {31'd0, skew_err}, 32'd0);
        check("t1_active", {31'd0, active}, 32'd0);
        q0.delete();
        q1.delete();
        upd();
        reset = 1'b0;
        tick();

        // 2: four-word packet, full throughput, then back to IDLE
        q0 = {32'hA0, 32'hA2};
        q1 = {32'hA1, 32'hA3};
        upd();
        tick();
        check("t2_n1_valid", {31'd0, valid_out}, 32'd0);
        check("t2_n1_active", {31'd0, active}, 32'd1);
        expect_word("t2_a0", 32'hA0);
        expect_word("t2_a1", 32'hA1);
        expect_word("t2_a2", 32'hA2);
        expect_word("t2_a3", 32'hA3);
        tick();
        check("t2_end_valid", {31'd0, valid_out}, 32'd0);
        check("t2_end_hold", data_out, 32'hA3);
        check("t2_end_idle", {31'd0, active}, 32'd0);

        // 3: backpressure for 3 cycles after A1
        q0 = {32'hA0, 32'hA2};
        q1 = {32'hA1, 32'hA3};
        upd();
        tick();
        expect_word("t3_a0", 32'hA0);
        expect_word("t3_a1", 32'hA1);
        ready_out = 1'b0;
        #1;
        check("t3_nopop", {31'd0, pop_0}, 32'd0);
        repeat (3) begin
            tick();
            check("t3_stall_valid", {31'd0, valid_out}, 32'd0);
            check("t3_stall_hold", data_out, 32'hA1);
        end
        check("t3_no_loss", q0.size(), 32'd1);
        ready_out = 1'b1;
        expect_word("t3_a2", 32'hA2);
        expect_word("t3_a3", 32'hA3);
        tick();

        // 4: lane 1 arrives 3 cycles late, within SKEW_MAX
        q0 = {32'hB0, 32'hB2};
        upd();
        repeat (3) tick();
        check("t4_align_active", {31'd0, active}, 32'd0);
        q1 = {32'hB1, 32'hB3};
        upd();
        tick();
        expect_word("t4_b0", 32'hB0);
        expect_word("t4_b1", 32'hB1);
        expect_word("t4_b2", 32'hB2);
        expect_word("t4_b3", 32'hB3);
        tick();
        check("t4_no_err", {31'd0, skew_err}, 32'd0);

        // 5: skew error from ALIGN, twice
        run_align_err(1'b0);
        run_align_err(1'b1);
        check("t5_sticky", {31'd0, skew_err}, 32'd1);
`ifdef UNSTRIPE_ERRCNT_EN
        check("t5_err_count", {24'd0, err_count}, 32'd2);
`endif

        // Lane 1 stalls mid-packet in RUN1 until the skew limit trips
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t7_rst_clear", {31'd0, skew_err}, 32'd0);
`ifdef UNSTRIPE_ERRCNT_EN
        check("t7_cnt_clear", {24'd0, err_count}, 32'd0);
`endif
        q0 = {32'hE0, 32'hE2};
        q1 = {32'hE1};
        upd();
        tick();
        expect_word("t7_e0", 32'hE0);
        expect_word("t7_e1", 32'hE1);
        expect_word("t7_e2", 32'hE2);
        repeat (3) tick();
        check("t7_pre_err", {31'd0, skew_err}, 32'd0);
        check("t7_pre_active", {31'd0, active}, 32'd1);
        tick();
        check("t7_err", {31'd0, skew_err}, 32'd1);
        check("t7_err_active", {31'd0, active}, 32'd0);
        tick();

        // 6: reset while in RUN1 mid-packet
        q0 = {32'hA0, 32'hA2};
        q1 = {32'hA1, 32'hA3};
        upd();
        tick();
        expect_word("t6_a0", 32'hA0);
        reset = 1'b1;
        #1;
        check("t6_rst_pop1", {31'd0, pop_1}, 32'd0);
        tick();
        check("t6_valid", {31'd0, valid_out}, 32'd0);
        check("t6_data", data_out, 32'd0);
        check("t6_skew", {31'd0, skew_err}, 32'd0);
        check("t6_idle", {31'd0, active}, 32'd0);
        check("t6_q1_kept", q1.size(), 32'd2);
        q0.delete();
        q1.delete();
        upd();
        reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
